port_io_bank: RTL and testbench

Parametrised I/O bank between board pads and the 8051 core's parallel ports. Replaces the direct wiring of key pads to `p1_i`/`p2_i` and of `p1_o`/`p2_o` to GPIO pads.
- Input side: every pad is synchronised and debounced, and each settled level change raises a sticky per-bit change flag with a maskable interrupt request.
- Output side: core port values are registered, with per-bit polarity inversion, before driving the pads.

Sits in the board top between pads and `mc8051_top`, clocked by the MCU clock.

---
 rtl/port_io_pkg.sv | 12 +
 rtl/debounce_cell.sv | 50 +++++
 rtl/port_io_bank.sv | 66 ++++++
 tb/tb_port_io_bank.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/port_io_pkg.sv
// Shared constants and index helper for the parallel-port I/O bank.
// Bit b of port p sits at flat position p*PORT_W + b on every bank-wide bus.
package port_io_pkg;

    localparam int PORT_W             = 8;
    localparam int DEB_CYCLES_DEFAULT = 50000;

    function automatic int flat_idx(input int port, input int bit_idx);
        return port * PORT_W + bit_idx;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input channel: two-flop synchroniser, debounce counter and accepted level.
// chg_pulse is high during the cycle whose closing edge accepts a new level.
module debounce_cell
    import port_io_pkg::*;
#(
    parameter int   DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int   CNT_W      = $clog2(DEB_CYCLES + 1),
    parameter logic IN_RST     = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic pad,
    output logic level,
    output logic chg_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             d;
    logic [CNT_W-1:0] cnt;
    logic             at_limit;

    assign at_limit  = (cnt == CNT_LAST);
    // Combinational so the bank's sticky flag is set on the same edge that updates d.
    assign chg_pulse = (s2 != d) && at_limit;
    assign level     = d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1  <= IN_RST;
            s2  <= IN_RST;
            d   <= IN_RST;
            cnt <= '0;
        end else begin
            s1 <= pad;
            s2 <= s1;
            if (s2 == d) begin
                cnt <= '0;
            end else if (at_limit) begin
                d   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/port_io_bank.sv
// I/O bank between board pads and the core's parallel ports: debounced inputs with
// sticky change flags and a maskable irq, plus registered polarity-adjustable outputs.
module port_io_bank
    import port_io_pkg::*;
#(
    parameter int                         NPORTS     = 2,
    parameter int                         DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int                         CNT_W      = $clog2(DEB_CYCLES + 1),
    parameter logic [PORT_W*NPORTS-1:0]   IN_RST     = '1,
    parameter logic [PORT_W*NPORTS-1:0]   OUT_RST    = '1,
    parameter logic [PORT_W*NPORTS-1:0]   OUT_INV    = '0
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic [PORT_W*NPORTS-1:0]   pad_i,
    output logic [PORT_W*NPORTS-1:0]   port_i,
    input  logic [PORT_W*NPORTS-1:0]   port_o,
    output logic [PORT_W*NPORTS-1:0]   pad_o,
    output logic [PORT_W*NPORTS-1:0]   chg_o,
    input  logic [PORT_W*NPORTS-1:0]   chg_clr_i,
    input  logic [PORT_W*NPORTS-1:0]   chg_en_i,
    output logic                       irq_o
);

    localparam int W = PORT_W * NPORTS;

    logic [W-1:0] chg_pulse;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        for (genvar b = 0; b < PORT_W; b++) begin : g_bit
            localparam int I = flat_idx(p, b);

            debounce_cell #(
                .DEB_CYCLES (DEB_CYCLES),
                .CNT_W      (CNT_W),
                .IN_RST     (IN_RST[I])
            ) u_cell (
                .clk       (clk),
                .n_reset   (n_reset),
                .pad       (pad_i[I]),
                .level     (port_i[I]),
                .chg_pulse (chg_pulse[I])
            );
        end
    end

    // A new acceptance overrides a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            chg_o <= '0;
            irq_o <= 1'b0;
        end else begin
            chg_o <= (chg_o & ~chg_clr_i) | chg_pulse;
            irq_o <= |(chg_o & chg_en_i);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pad_o <= OUT_RST;
        end else begin
            pad_o <= port_o ^ OUT_INV;
        end
    end

endmodule

// File: tb/tb_port_io_bank.sv
// Bench for port_io_bank: directed scenarios plus random traffic, checked every cycle
// against a sliding-window reference model through an expected-value queue.
module tb_port_io_bank;
    import port_io_pkg::*;

    localparam int NP = 2;
    localparam int W = 16;
    localparam int DEB = 4;
    localparam int EW = 4 * W + 1;
    localparam logic [W-1:0] INV_MASK = 16'h00FF;
    localparam logic [W-1:0] ONES = 16'hFFFF;

    logic clk = 1'b0;
    logic n_reset;
    logic [W-1:0] pad_i, port_o, chg_clr_i, chg_en_i;
    logic [W-1:0] port_i, pad_o, chg_o;
    logic irq_o;
    logic [W-1:0] port_i_b, pad_o_b, chg_o_b;
    logic irq_o_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    // reference model state
    logic [W-1:0] m_d, m_chg, m_pad, m_pad_b;
    logic m_irq;
    logic [W-1:0] dly_q[$];
    logic [W-1:0] win_q[$];
    logic [W-1:0] m_sync, m_flip;
    logic m_all;

    always #5 clk = ~clk;

    port_io_bank #(.NPORTS(NP), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .n_reset(n_reset), .pad_i(pad_i), .port_i(port_i),
        .port_o(port_o), .pad_o(pad_o), .chg_o(chg_o),
        .chg_clr_i(chg_clr_i), .chg_en_i(chg_en_i), .irq_o(irq_o)
    );

    port_io_bank #(.NPORTS(NP), .DEB_CYCLES(DEB), .OUT_INV(INV_MASK)) dut_inv (
        .clk(clk), .n_reset(n_reset), .pad_i(pad_i), .port_i(port_i_b),
        .port_o(port_o), .pad_o(pad_o_b), .chg_o(chg_o_b),
        .chg_clr_i(chg_clr_i), .chg_en_i(chg_en_i), .irq_o(irq_o_b)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        m_d = ONES;
        m_chg = '0;
        m_irq = 1'b0;
        m_pad = ONES;
        m_pad_b = ONES;
        dly_q = '{ONES, ONES};
        win_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_port_i"}, port_i, ONES);
        check({tag, "_chg_o"}, chg_o, '0);
        check({tag, "_irq_o"}, W'(irq_o), '0);
        check({tag, "_pad_o"}, pad_o, ONES);
        check({tag, "_pad_o_inv"}, pad_o_b, ONES);
    endtask

    // A level is accepted once the last DEB synchronised samples all disagree with it.
    always @(posedge clk) begin
        if (!n_reset) begin
            model_reset();
        end else begin
            m_sync = dly_q.pop_front();
            dly_q.push_back(pad_i);
            win_q.push_back(m_sync);
            if (win_q.size() > DEB) void'(win_q.pop_front());
            m_flip = '0;
            if (win_q.size() == DEB) begin
                for (int i = 0; i < W; i++) begin
                    m_all = 1'b1;
                    foreach (win_q[j]) if (win_q[j][i] == m_d[i]) m_all = 1'b0;
                    m_flip[i] = m_all;
                end
            end
            m_irq = |(m_chg & chg_en_i);
            m_chg = (m_chg & ~chg_clr_i) | m_flip;
            m_d = m_d ^ m_flip;
            m_pad = port_o;
            m_pad_b = port_o ^ INV_MASK;
        end
        exp_q.push_back({m_irq, m_chg, m_d, m_pad, m_pad_b});
    end

    // An asynchronous reset voids the entry queued at the last edge.
    always @(negedge n_reset) begin
        exp_q.delete();
        model_reset();
    end

    initial begin : monitor
        logic [EW-1:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                if (!n_reset) check_reset_values("mon_rst");
                else check("queue_empty", '1, '0);
            end else begin
                e = exp_q.pop_front();
                check("port_i", port_i, e[3*W-1:2*W]);
                check("chg_o", chg_o, e[4*W-1:3*W]);
                check("irq_o", W'(irq_o), W'(e[EW-1]));
                check("pad_o", pad_o, e[2*W-1:W]);
                check("pad_o_inv", pad_o_b, e[W-1:0]);
            end
        end
    end

    initial begin : stimulus
        int b;
        n_reset = 1'b0;
        pad_i = ONES;
        port_o = ONES;
        chg_clr_i = '0;
        chg_en_i = '0;
        model_reset();
        tick(3);
        check_reset_values("in_rst");
        n_reset = 1'b1;
        tick(2);
        check("post_rst_port_i", port_i, ONES);
        check("post_rst_pad_o", pad_o, ONES);

        port_o = 16'hA55A;
        tick(1);
        check("out_pad_o", pad_o, 16'hA55A);
        check("out_pad_o_inv", pad_o_b, 16'hA5A5);

        // clean press on bit 3
        chg_en_i = 16'h0008;
        pad_i[3] = 1'b0;
        tick(5);
        check("press_early", W'(port_i[3]), W'(1'b1));
        tick(1);
        check("press_level", W'(port_i[3]), W'(1'b0));
        check("press_flag", W'(chg_o[3]), W'(1'b1));
        check("press_irq_late", W'(irq_o), '0);
        tick(1);
        check("press_irq", W'(irq_o), W'(1'b1));
        chg_clr_i = 16'h0008;
        tick(1);
        chg_clr_i = '0;
        check("clr_flag", W'(chg_o[3]), '0);
        check("clr_irq_hold", W'(irq_o), W'(1'b1));
        tick(1);
        check("clr_irq_fall", W'(irq_o), '0);

        // glitch rejection on bit 9, then an accepted 4-cycle pulse
        pad_i[9] = 1'b0;
        tick(3);
        pad_i[9] = 1'b1;
        tick(8);
        check("glitch_level", W'(port_i[9]), W'(1'b1));
        check("glitch_flag", W'(chg_o[9]), '0);
        pad_i[9] = 1'b0;
        tick(4);
        pad_i[9] = 1'b1;
        tick(3);
        check("pulse4_level", W'(port_i[9]), '0);
        check("pulse4_flag", W'(chg_o[9]), W'(1'b1));
        tick(8);

        // clear colliding with an accepted release on bit 3
        pad_i[3] = 1'b1;
        tick(5);
        chg_clr_i = 16'h0008;
        tick(1);
        chg_clr_i = '0;
        check("coll_flag", W'(chg_o[3]), W'(1'b1));
        check("coll_level", W'(port_i[3]), W'(1'b1));
        tick(2);
        chg_clr_i = 16'h0008;
        tick(1);
        chg_clr_i = '0;
        check("coll_clr", W'(chg_o[3]), '0);
        tick(1);
        check("coll_irq_fall", W'(irq_o), '0);

        // simultaneous changes with only bit 8 enabled
        chg_clr_i = ONES;
        tick(1);
        chg_clr_i = '0;
        chg_en_i = 16'h0100;
        pad_i[0] = 1'b0;
        pad_i[8] = 1'b0;
        pad_i[15] = 1'b0;
        tick(6);
        check("multi_flags", chg_o & 16'h8101, 16'h8101);
        check("multi_irq_late", W'(irq_o), '0);
        tick(1);
        check("multi_irq", W'(irq_o), W'(1'b1));
        chg_clr_i = 16'h0100;
        tick(1);
        chg_clr_i = '0;
        check("multi_clr8", chg_o & 16'h8101, 16'h8001);
        tick(1);
        check("multi_irq_fall", W'(irq_o), '0);

        // reset in the middle of a debounce on bit 5
        pad_i[5] = 1'b0;
        tick(2);
        n_reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        tick(2);
        n_reset = 1'b1;
        tick(5);
        check("rerun_early", W'(port_i[5]), W'(1'b1));
        tick(1);
        check("rerun_level", W'(port_i[5]), '0);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, W - 1);
                pad_i[b] = ~pad_i[b];
            end
            chg_clr_i = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) chg_en_i = W'($urandom);
            port_o = W'($urandom);
            if (c == 300) begin
                n_reset = 1'b0;
                tick(1);
                n_reset = 1'b1;
            end
            tick(1);
        end
        chg_clr_i = '0;
        tick(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
